// File: rtl/pc_pkg.sv
// Shared select-code constants for the program counter and the control unit driving it.
package pc_pkg;

    localparam int OPT_SIZE = 3;

    localparam logic [OPT_SIZE-1:0] NEXT_INSTR   = 3'd0;
    localparam logic [OPT_SIZE-1:0] KEEP_INSTR   = 3'd1;
    localparam logic [OPT_SIZE-1:0] LOAD_INSTR   = 3'd2;
    localparam logic [OPT_SIZE-1:0] BRANCH_INSTR = 3'd3;
    localparam logic [OPT_SIZE-1:0] CALL_INSTR   = 3'd4;
    localparam logic [OPT_SIZE-1:0] RET_INSTR    = 3'd5;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: registered entries plus depth counter; push/pop land on the next edge.
// No backpressure: push while full and pop while empty are silently dropped.
module pc_ret_stack #(
    parameter int ADDR_SIZE   = 14,
    parameter int STACK_DEPTH = 8,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ADDR_SIZE-1:0] din,
    output logic [ADDR_SIZE-1:0] top,
    output logic [DW-1:0]        depth,
    output logic                 full,
    output logic                 empty
);

    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

    logic [ADDR_SIZE-1:0] mem_q [STACK_DEPTH];
    logic [ADDR_SIZE-1:0] mem_d [STACK_DEPTH];
    logic [DW-1:0]        depth_q, depth_d;
    logic [IW-1:0]        wr_idx, rd_idx;

    assign full   = (depth_q == DEPTH_MAX);
    assign empty  = (depth_q == '0);
    assign depth  = depth_q;
    assign wr_idx = IW'(depth_q);
    assign rd_idx = IW'(depth_q - DW'(1));
    assign top    = mem_q[rd_idx];

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            depth_d       = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) depth_q <= '0;
        else      depth_q <= depth_d;
    end

    // Entry storage is deliberately left out of reset; depth alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with relative branch and call/return via a return-address stack; 1-cycle latency.
// No backpressure: overflowing CALL / underflowing RET hold the PC and raise sticky error flags.
module pc_stack
    import pc_pkg::*;
#(
    parameter int                   ADDR_SIZE    = 14,
    parameter int                   STACK_DEPTH  = 8,
    parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPT_SIZE-1:0]  sel,
    input  logic [ADDR_SIZE-1:0] operand,
    output logic [ADDR_SIZE-1:0] out,
    output logic [DW-1:0]        depth,
    output logic                 full,
    output logic                 empty,
    output logic                 err_ovf,
    output logic                 err_udf
);

    logic [ADDR_SIZE-1:0] out_q, out_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_udf_q, err_udf_d;
    logic                 push, pop;
    logic [ADDR_SIZE-1:0] ret_addr, stk_top;
    logic                 stk_full, stk_empty;

    assign ret_addr = out_q + ADDR_SIZE'(1);

    always_comb begin
        out_d     = out_q;
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        push      = 1'b0;
        pop       = 1'b0;
        case (sel)
            NEXT_INSTR:   out_d = ret_addr;
            KEEP_INSTR:   out_d = out_q;
            LOAD_INSTR:   out_d = operand;
            // Offset is two's complement, so a plain truncating add covers both directions.
            BRANCH_INSTR: out_d = out_q + operand;
            CALL_INSTR: begin
                if (stk_full) begin
                    err_ovf_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    out_d = operand;
                end
            end
            RET_INSTR: begin
                if (stk_empty) begin
                    err_udf_d = 1'b1;
                end else begin
                    pop   = 1'b1;
                    out_d = stk_top;
                end
            end
            default:      out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q     <= RESET_VECTOR;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    pc_ret_stack #(
        .ADDR_SIZE  (ADDR_SIZE),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_ret_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (ret_addr),
        .top  (stk_top),
        .depth(depth),
        .full (stk_full),
        .empty(stk_empty)
    );

    assign out     = out_q;
    assign full    = stk_full;
    assign empty   = stk_empty;
    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
Parametrised program counter for the processor module. It is the successor of the basic next/keep/load PC.
- Adds relative branch, subroutine call and return via an internal return-address stack (LIFO).
- Exposes stack-depth and sticky error status.
- Sits between the control unit, which drives sel, and the instruction-memory address port.

Parameters:
ADDR_SIZE, 14, width of PC, operand and stack entries; all PC arithmetic is modulo 2^ADDR_SIZE
STACK_DEPTH, 8, number of return-address entries (>=1)
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets the block)
sel  input  3  operation select (codes below)
operand  input  ADDR_SIZE  absolute target (JUMP/CALL) or two's-complement offset (BRANCH)
out  output  ADDR_SIZE  current PC (registered)
depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
full  output  1  depth==STACK_DEPTH
empty  output  1  depth==0
err_ovf  output  1  sticky: CALL attempted while full
err_udf  output  1  sticky: RET attempted while empty

Behaviour:
- Reset (rst==0 at posedge): out=RESET_VECTOR, depth=0, empty=1, full=0, err_ovf=0, err_udf=0.
  - Stack RAM contents are not reset.
  - Reset overrides any sel value, including mid-call sequences.
- sel codes, all taking effect at the next posedge (1-cycle latency):
  - 0 NEXT: out<=out+1.
  - 1 KEEP: out unchanged.
  - 2 JUMP: out<=operand.
  - 3 BRANCH: out<=out+operand, with operand as signed ADDR_SIZE; relative to the current out, not out+1.
  - 4 CALL: push (out+1) onto the stack, depth<=depth+1, out<=operand.
  - 5 RET: out<=top of stack, depth<=depth-1.
  - 6, 7 reserved: behave as KEEP; no flag change.
- Wrap-around:
  - out+1 at all-ones gives 0.
  - BRANCH sums truncate to ADDR_SIZE bits.
  - A pushed return address of all-ones+1 is stored as 0.
- CALL when full:
  - No push; depth unchanged; out unchanged (holds, does not jump); err_ovf<=1.
- RET when empty:
  - out unchanged; depth stays 0; err_udf<=1.
- err_ovf and err_udf are sticky until reset. Once set, they do not block further legal operations.
- full and empty are combinational decodes of the registered depth. They are valid in the same cycle as depth.
- The stack is strictly LIFO.
  - CALL writes entry[depth]; RET reads entry[depth-1].
  - CALL then RET returns to the instruction after the call.
- Only one operation is possible per cycle, so there are no simultaneous push and pop.
- No combinational path exists from sel or operand to out.

Decomposition:
- Shared package pc_pkg:
  - localparam OPT_SIZE=3.
  - sel code constants NEXT_INSTR=0, KEEP_INSTR=1, LOAD_INSTR=2, BRANCH_INSTR=3, CALL_INSTR=4, RET_INSTR=5.
  - Used by the control unit and the bench.
- Sub-module pc_ret_stack (parameters ADDR_SIZE, STACK_DEPTH):
  - Registered array plus depth counter, with push/pop/din/top/depth/full/empty.
  - Ignores push when full and pop when empty.
  - pc_stack owns the sel decode, out register and error flags.

Test Plan:
- Reset then 3x NEXT with RESET_VECTOR=0 -> out 0,1,2,3; depth=0, empty=1, no errors. Assert rst=0 mid-sequence -> next cycle out=0.
- At out=5: BRANCH operand=14'h3FFE (-2) -> out=3. BRANCH operand=10 -> out=13. At out=14'h3FFF: NEXT -> out=0.
- At out=0x20: CALL operand=0x100 -> out=0x100, depth=1. NEXT twice -> 0x102. RET -> out=0x21, depth=0, empty=1.
- Nested: 8 CALLs (STACK_DEPTH=8) from distinct PCs -> full=1. 9th CALL operand=0x300 -> out unchanged, depth=8, err_ovf=1. 8 RETs -> return addresses in reverse order, empty=1.
- RET with empty stack at out=0x40 -> out=0x40, err_udf=1. Following JUMP operand=0x10 -> out=0x10, err_udf remains 1 until reset.
- sel=6 and sel=7 at out=0x55 -> out=0x55, depth and flags unchanged. KEEP for 3 cycles -> out stable.
